// File: rtl/fifo_arbiter.sv
// Four-lane round-robin write arbiter in front of a flagless shared FIFO.
// Issues one WRITE, READ or IDLE per cycle and keeps the FIFO's shadow occupancy count.
module fifo_arbiter #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned LOG_DEPTH = 4,
   parameter int unsigned WIDTH     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             req,
   input  logic [4*WIDTH-1:0]     req_data,
   output logic [3:0]             grant,
   output logic                   fifo_clear,
   output logic                   fifo_write_enable,
   output logic [WIDTH-1:0]       fifo_write_data,
   output logic                   fifo_read_enable,
   input  logic [WIDTH-1:0]       fifo_read_data,
   input  logic                   fifo_valid,
   input  logic                   pop_req,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   pop_valid,
   output logic [LOG_DEPTH:0]     occupancy,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned OCC_W     = LOG_DEPTH + 1;
   localparam int unsigned LANE_W    = 2;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2
   } op_e;

   typedef enum logic {
      LAST_WRITE = 1'b0,
      LAST_READ  = 1'b1
   } last_op_e;

   logic [NUM_LANES-1:0] grant_q,  grant_d;
   logic                 clear_q,  clear_d;
   logic                 we_q,     we_d;
   logic [WIDTH-1:0]     wdata_q,  wdata_d;
   logic                 re_q,     re_d;
   logic [OCC_W-1:0]     occ_q,    occ_d;
   logic [LANE_W-1:0]    rr_ptr_q, rr_ptr_d;
   last_op_e             last_op_q, last_op_d;

   logic [NUM_LANES-1:0] lane_elig;
   logic                 lane_found;
   logic [LANE_W-1:0]    sel_lane;
   logic [LANE_W-1:0]    probe;
   logic                 wr_ok;
   logic                 rd_ok;
   op_e                  op;

   // Round-robin search over lanes that requested and were not granted last cycle.
   always_comb begin
      lane_elig  = req & ~grant_q;
      lane_found = 1'b0;
      sel_lane   = '0;
      probe      = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         probe = rr_ptr_q + LANE_W'(k);
         if (!lane_found && lane_elig[probe]) begin
            lane_found = 1'b1;
            sel_lane   = probe;
         end
      end
   end

   // Operation select: write and read are mutually exclusive, conflicts alternate.
   always_comb begin
      wr_ok = lane_found && (occ_q < OCC_W'(DEPTH)) && !clear_q;
      rd_ok = pop_req && (occ_q != '0) && !clear_q;
      op    = OP_IDLE;
      if (wr_ok && rd_ok) begin
         op = (last_op_q == LAST_WRITE) ? OP_READ : OP_WRITE;
      end else if (wr_ok) begin
         op = OP_WRITE;
      end else if (rd_ok) begin
         op = OP_READ;
      end
   end

   // Next-state and registered strobes; occupancy moves at the issuing edge.
   always_comb begin
      grant_d   = '0;
      clear_d   = 1'b0;
      we_d      = 1'b0;
      wdata_d   = '0;
      re_d      = 1'b0;
      occ_d     = occ_q;
      rr_ptr_d  = rr_ptr_q;
      last_op_d = last_op_q;
      case (op)
         OP_WRITE: begin
            grant_d   = NUM_LANES'(1) << sel_lane;
            we_d      = 1'b1;
            wdata_d   = req_data[sel_lane*WIDTH +: WIDTH];
            occ_d     = occ_q + OCC_W'(1);
            rr_ptr_d  = sel_lane + LANE_W'(1);
            last_op_d = LAST_WRITE;
         end
         OP_READ: begin
            re_d      = 1'b1;
            occ_d     = occ_q - OCC_W'(1);
            last_op_d = LAST_READ;
         end
         default: begin
         end
      endcase
   end

   // clear_q resets high so the FIFO sees one clear edge after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q   <= '0;
         clear_q   <= 1'b1;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         re_q      <= 1'b0;
         occ_q     <= '0;
         rr_ptr_q  <= '0;
         last_op_q <= LAST_WRITE;
      end else begin
         grant_q   <= grant_d;
         clear_q   <= clear_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         re_q      <= re_d;
         occ_q     <= occ_d;
         rr_ptr_q  <= rr_ptr_d;
         last_op_q <= last_op_d;
      end
   end

   assign grant             = grant_q;
   assign fifo_clear        = clear_q;
   assign fifo_write_enable = we_q;
   assign fifo_write_data   = wdata_q;
   assign fifo_read_enable  = re_q;
   assign occupancy         = occ_q;
   assign full              = (occ_q == OCC_W'(DEPTH));
   assign empty             = (occ_q == '0);

   // Consumer passthrough, forced low while reset is held.
   assign pop_valid = fifo_valid & reset;
   assign pop_data  = reset ? fifo_read_data : '0;

endmodule
